// File: rtl/mult_pkg.sv
// Shared types and constants for the parametrised shift-add multiplier.
package mult_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADD   = 3'd1,
    SHIFT = 3'd2,
    STEP  = 3'd3,
    DONE  = 3'd4,
    HOLD  = 3'd5
  } state_t;

  localparam logic ADD_OP = 1'b0;
  localparam logic SUB_OP = 1'b1;

endpackage

// File: rtl/add_sub_n.sv
// Combinational (WIDTH+1)-bit sign-extending adder/subtractor; carry out is dropped.
module add_sub_n #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH:0]   sum
);

  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] b_ext;

  assign a_ext = {a[WIDTH-1], a};
  assign b_ext = {b[WIDTH-1], b};
  assign sum   = sub ? (a_ext - b_ext) : (a_ext + b_ext);

endmodule

// File: rtl/multiplier_param.sv
// Signed shift-add multiplier: product of latched multiplicand M and register B lands in {X,A,B}.
// Optional FAST mode merges the add and the shift of each bit into one STEP cycle.
module multiplier_param
  import mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter bit FAST  = 1'b0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] sw_i,
  input  logic             run_i,
  input  logic             load_clear_i,
  output logic [WIDTH-1:0] A_val,
  output logic [WIDTH-1:0] B_val,
  output logic             X_val,
  output logic             busy_o,
  output logic             done_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, m_q;
  logic             x_q;
  logic             run_q;
  logic [CW-1:0]    count_q;
  logic             busy_q, done_q;

  logic             start, last;
  logic             do_start, do_load, do_add, do_shift, do_step;
  logic             busy_d;
  logic [WIDTH:0]   sum, sel;

  // Handshake: a rising edge of run_i while idle starts one product; busy_o stays high
  // until the result is final, done_o pulses once, and run_i must drop before the next start.
  assign start = run_i & ~run_q & (state_q == IDLE);
  assign last  = (count_q == CW'(WIDTH - 1));

  add_sub_n #(.WIDTH(WIDTH)) u_add_sub (
    .a   (a_q),
    .b   (m_q),
    .sub (last ? SUB_OP : ADD_OP),
    .sum (sum)
  );

  // Multiplier bit 0 decides whether the partial product absorbs M this bit.
  assign sel = b_q[0] ? sum : {x_q, a_q};

  always_comb begin
    state_d  = state_q;
    do_start = 1'b0;
    do_load  = 1'b0;
    do_add   = 1'b0;
    do_shift = 1'b0;
    do_step  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          do_start = 1'b1;
          state_d  = FAST ? STEP : ADD;
        end else if (load_clear_i) begin
          do_load = 1'b1;
        end
      end
      ADD: begin
        do_add  = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        do_shift = 1'b1;
        state_d  = last ? DONE : ADD;
      end
      STEP: begin
        do_step = 1'b1;
        state_d = last ? DONE : STEP;
      end
      DONE:    state_d = HOLD;
      HOLD:    if (!run_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_d = (state_d == ADD) || (state_d == SHIFT) ||
                  (state_d == STEP) || (state_d == DONE);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      x_q     <= 1'b0;
      run_q   <= 1'b0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_i;
      busy_q  <= busy_d;
      done_q  <= (state_q == DONE);
      if (do_start) begin
        m_q     <= sw_i;
        a_q     <= '0;
        x_q     <= 1'b0;
        count_q <= '0;
      end
      if (do_load) begin
        b_q <= sw_i;
        a_q <= '0;
        x_q <= 1'b0;
      end
      if (do_add) begin
        {x_q, a_q} <= sel;
      end
      if (do_shift) begin
        a_q     <= {x_q, a_q[WIDTH-1:1]};
        b_q     <= {a_q[0], b_q[WIDTH-1:1]};
        count_q <= count_q + CW'(1);
      end
      if (do_step) begin
        x_q     <= sel[WIDTH];
        a_q     <= sel[WIDTH:1];
        b_q     <= {sel[0], b_q[WIDTH-1:1]};
        count_q <= count_q + CW'(1);
      end
    end
  end

  assign A_val  = a_q;
  assign B_val  = b_q;
  assign X_val  = x_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_multiplier_param.sv
// Bench for multiplier_param: WIDTH=8/FAST=0 and WIDTH=16/FAST=1 instances against an arithmetic model.
module tb_multiplier_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  sw0;  logic run0, lc0;  logic [7:0]  a0, b0;  logic x0, busy0, done0;
  logic [15:0] sw1;  logic run1, lc1;  logic [15:0] a1, b1;  logic x1, busy1, done1;

  int checks = 0;
  int errors = 0;

  multiplier_param #(.WIDTH(8), .FAST(1'b0)) dut8 (
    .Clk(clk), .Reset(rst), .sw_i(sw0), .run_i(run0), .load_clear_i(lc0),
    .A_val(a0), .B_val(b0), .X_val(x0), .busy_o(busy0), .done_o(done0)
  );

  multiplier_param #(.WIDTH(16), .FAST(1'b1)) dut16 (
    .Clk(clk), .Reset(rst), .sw_i(sw1), .run_i(run1), .load_clear_i(lc1),
    .A_val(a1), .B_val(b1), .X_val(x1), .busy_o(busy1), .done_o(done1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mask(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic longint sext(input logic [63:0] v, input int w);
    longint t;
    t = longint'(v << (64 - w));
    return t >>> (64 - w);
  endfunction

  // Model: per instance, width, cycles from the start edge to the final step, and a phase
  // (0 idle, 1 computing, 2 waiting for run to drop). n counts clock edges since the start edge.
  int          width_m[2] = '{8, 16};
  int          lat_m[2]   = '{16, 16};
  int          phase_m[2] = '{0, 0};
  int          n_m[2]     = '{-1, -1};
  bit          run_prev_m[2] = '{1'b0, 1'b0};
  logic [63:0] abx_m[2]   = '{64'd0, 64'd0};
  logic [32:0] exp_q0[$];
  logic [32:0] exp_q1[$];

  always @(negedge clk) begin
    logic [63:0] act_abx, sw_a, exp_v;
    logic        busy_a, done_a, run_a, lc_a, exp_busy, exp_done;
    longint      prod;
    int          w, lat;
    for (int i = 0; i < 2; i++) begin
      w   = width_m[i];
      lat = lat_m[i];
      if (i == 0) begin
        act_abx = 64'({x0, a0, b0}); sw_a = 64'(sw0);
        busy_a = busy0; done_a = done0; run_a = run0; lc_a = lc0;
      end else begin
        act_abx = 64'({x1, a1, b1}); sw_a = 64'(sw1);
        busy_a = busy1; done_a = done1; run_a = run1; lc_a = lc1;
      end
      if (rst) begin
        check($sformatf("rst_abx%0d", i), act_abx, 64'd0);
        check($sformatf("rst_busy%0d", i), 64'(busy_a), 64'd0);
        check($sformatf("rst_done%0d", i), 64'(done_a), 64'd0);
        phase_m[i] = 0; n_m[i] = -1; run_prev_m[i] = 1'b0; abx_m[i] = 64'd0;
        if (i == 0) exp_q0.delete(); else exp_q1.delete();
      end else begin
        exp_busy = (phase_m[i] == 1) && (n_m[i] <= lat);
        exp_done = (phase_m[i] == 1) && (n_m[i] == lat + 1);
        if (exp_done) begin
          if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
            checks++; errors++;
            $display("FAIL sb_underflow%0d actual=empty required=entry", i);
          end else begin
            exp_v = (i == 0) ? 64'(exp_q0.pop_front()) : 64'(exp_q1.pop_front());
            abx_m[i] = exp_v;
          end
        end
        check($sformatf("busy%0d", i), 64'(busy_a), 64'(exp_busy));
        check($sformatf("done%0d", i), 64'(done_a), 64'(exp_done));
        if (phase_m[i] != 1 || exp_done)
          check($sformatf("abx%0d", i), act_abx, abx_m[i]);
        case (phase_m[i])
          0: begin
            if (run_a && !run_prev_m[i]) begin
              prod = sext(sw_a, w) * sext(abx_m[i] & mask(w), w);
              if (i == 0) exp_q0.push_back(33'(64'(prod) & mask(2 * w + 1)));
              else        exp_q1.push_back(33'(64'(prod) & mask(2 * w + 1)));
              phase_m[i] = 1; n_m[i] = 0;
            end else if (lc_a) begin
              abx_m[i] = sw_a;
            end
          end
          1: begin
            if (n_m[i] == lat + 1) begin
              n_m[i] = -1;
              phase_m[i] = run_a ? 2 : 0;
            end else begin
              n_m[i] = n_m[i] + 1;
            end
          end
          default: if (!run_a) phase_m[i] = 0;
        endcase
        run_prev_m[i] = run_a;
      end
    end
  end

  task automatic load(input int i, input logic [15:0] s);
    @(posedge clk); #2;
    if (i == 0) begin sw0 = s[7:0]; lc0 = 1'b1; end else begin sw1 = s; lc1 = 1'b1; end
    @(posedge clk); #2;
    if (i == 0) lc0 = 1'b0; else lc1 = 1'b0;
  endtask

  // Start a product, scramble sw_i after the start edge, optionally pulse load_clear while
  // busy, wait for done_o, then keep run high for hold_cyc cycles before releasing it.
  task automatic run_op(input int i, input logic [15:0] s, input bit mid_lc, input int hold_cyc,
                        output int lat, output logic [63:0] res);
    int extra;
    @(posedge clk); #2;
    if (i == 0) begin sw0 = s[7:0]; run0 = 1'b1; end else begin sw1 = s; run1 = 1'b1; end
    @(posedge clk); #2;
    if (i == 0) begin sw0 = ~s[7:0]; lc0 = mid_lc; end else begin sw1 = ~s; lc1 = mid_lc; end
    lat = -1;
    res = 64'd0;
    for (int c = 0; c <= 100; c++) begin
      @(negedge clk);
      if ((i == 0 && done0) || (i == 1 && done1)) begin
        lat = c;
        res = (i == 0) ? 64'({x0, a0, b0}) : 64'({x1, a1, b1});
        break;
      end
      if (c == 0) begin
        @(posedge clk); #2;
        if (i == 0) lc0 = 1'b0; else lc1 = 1'b0;
      end
    end
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL done_timeout%0d actual=none required=pulse", i);
    end
    extra = 0;
    repeat (hold_cyc) begin
      @(negedge clk);
      if ((i == 0 && done0) || (i == 1 && done1)) extra++;
    end
    check($sformatf("single_done%0d", i), 64'(extra), 64'd0);
    @(posedge clk); #2;
    if (i == 0) run0 = 1'b0; else run1 = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  typedef struct { logic [7:0] b; logic [7:0] s; logic [16:0] exp; } vec_t;
  vec_t vecs[6] = '{
    '{8'h80, 8'h80, 17'h04000},
    '{8'hFF, 8'hFF, 17'h00001},
    '{8'h00, 8'h5A, 17'h00000},
    '{8'h37, 8'h00, 17'h00000},
    '{8'h7F, 8'h7F, 17'h03F01},
    '{8'h80, 8'h7F, 17'h1C080}
  };

  initial begin
    int          lat;
    logic [63:0] res;
    rst = 1'b1;
    sw0 = '0; run0 = 1'b0; lc0 = 1'b0;
    sw1 = '0; run1 = 1'b0; lc1 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_outputs", 64'({x0, a0, b0, busy0, done0}), 64'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    load(0, 16'h0007);
    run_op(0, 16'h00C5, 1'b0, 0, lat, res);
    check("lat_w8", 64'(lat), 64'd17);
    check("prod_07_c5", res, 64'h1FE63);
    run_op(0, 16'h0002, 1'b0, 0, lat, res);
    check("b2b_63_02", res, 64'h000C6);

    foreach (vecs[k]) begin
      load(0, {8'h00, vecs[k].b});
      run_op(0, {8'h00, vecs[k].s}, 1'b0, 0, lat, res);
      check($sformatf("vec%0d", k), res, 64'(vecs[k].exp));
    end

    load(0, 16'h0001);
    run_op(0, 16'h0080, 1'b1, 40, lat, res);
    check("held_run_lc_ignored", res, 64'h1FF80);

    @(posedge clk); #2;
    sw0 = 8'h55; run0 = 1'b1;
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("reset_mid_op", 64'({x0, a0, b0, busy0, done0}), 64'd0);
    @(posedge clk); #2;
    run0 = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    load(0, 16'h0005);
    run_op(0, 16'h0003, 1'b0, 0, lat, res);
    check("after_reset", res, 64'h0000F);

    load(1, 16'h7FFF);
    run_op(1, 16'h8000, 1'b0, 3, lat, res);
    check("lat_w16_fast", 64'(lat), 64'd17);
    check("prod_7fff_8000", res, 64'h1C0008000);
    load(1, 16'h0003);
    run_op(1, 16'hFFFE, 1'b0, 0, lat, res);
    check("prod_3_m2", res, 64'h1FFFFFFFA);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multiplier_param.md
Name: multiplier_param

Overview:
Parametrised signed shift-add multiplier. Successor to the 8-bit multiplier datapath and controller.
- Computes the two's-complement product of a switch operand S and the held register B; result is held in {A,B} with sign/extension bit X.
- Adds a latched multiplicand, edge-triggered run, a busy/done handshake and an optional one-cycle-per-bit mode.
- Sits between the switch/button inputs and the hex display drivers of the lab top level.

Parameters:
WIDTH, 8, operand width in bits; product is 2*WIDTH bits in {A,B}.
FAST, 0, 0 = separate ADD and SHIFT cycles per bit; 1 = add and shift merged into one cycle per bit.

Ports:
Clk  input  1  system clock, rising-edge.
Reset  input  1  asynchronous, active-high reset.
sw_i  input  WIDTH  switch operand: multiplicand S at run, or the B load value.
run_i  input  1  start request, level; acted on at its rising edge only.
load_clear_i  input  1  in IDLE: B <= sw_i, A <= 0, X <= 0.
A_val  output  WIDTH  upper product half / accumulator.
B_val  output  WIDTH  lower product half / multiplier.
X_val  output  1  sign extension bit of A.
busy_o  output  1  high while a multiplication is in progress.
done_o  output  1  one-cycle pulse when the product is final.

Behaviour:
- Reset (async, any state): A=0, B=0, X=0, M=0, run_q=0, bit counter=0, state=IDLE; busy_o=0, done_o=0.
- run_q registers run_i every cycle. start = run_i & ~run_q & (state==IDLE).
- IDLE:
  - start has priority over load_clear_i: M <= sw_i, A <= 0, X <= 0, count <= 0, state <= ADD.
  - Otherwise load_clear_i: B <= sw_i, A <= 0, X <= 0.
  - sw_i changes after the start edge have no effect (M is latched).
- ADD (FAST=0):
  - If B[0]=1: {X,A} <= sext(A) + sext(M) for count<WIDTH-1, sext(A) - sext(M) for count==WIDTH-1. Arithmetic is WIDTH+1 bits, carry out discarded.
  - If B[0]=0: {X,A} unchanged.
  - state <= SHIFT.
- SHIFT (FAST=0):
  - {X,A,B} <= {X,X,A,B[WIDTH-1:1]} (arithmetic right shift, X preserved).
  - count++. state <= DONE if count==WIDTH-1, else ADD.
- FAST=1: single STEP state performs the ADD then the SHIFT on the sum in one cycle, with the same counting and the same last-bit subtract.
- DONE: done_o=1 for this cycle only; state <= HOLD.
- HOLD: wait until run_i==0, then state <= IDLE. A run held high yields exactly one multiplication.
- busy_o = 1 in ADD/SHIFT/STEP/DONE, 0 in IDLE and HOLD.
- Latency from the start edge to DONE: 2*WIDTH cycles (FAST=0) or WIDTH cycles (FAST=1). done_o asserts in the following cycle.
- load_clear_i and run_i edges outside IDLE are ignored. A run_i edge arriving during HOLD does not start a new operation.
- Back-to-back runs multiply the current B (low half of the previous product) by the new switch value; A and X are cleared at start.
- Boundary cases:
  - S = B = -2^(WIDTH-1) gives +2^(2*WIDTH-2) with X=0.
  - Zero operands give zero.
  - Reset mid-operation aborts immediately to reset values.
- Outputs are direct register values: no combinational path from inputs.

Decomposition:
- Package mult_pkg holds the state_t enum (IDLE, ADD, SHIFT, STEP, DONE, HOLD) and the ADD_OP/SUB_OP constants.
- Sub-module add_sub_n #(WIDTH): combinational (WIDTH+1)-bit sign-extending adder/subtractor with sub select.
- Controller and datapath registers stay in multiplier_param.

Test Plan:
- WIDTH=8 FAST=0: load_clear with sw=0x07, run with sw=0xC5 -> A=0xFE, B=0x63, X=1; done_o pulses exactly 17 cycles after the start edge.
- Then run again with sw=0x02 (B=0x63) -> A=0x00, B=0xC6, X=0; A/X cleared at start, not accumulated.
- WIDTH=8: B=0x80, S=0x80 -> A=0x40, B=0x00, X=0. B=0xFF, S=0xFF -> A=0x00, B=0x01.
- run_i held high for 40 cycles -> exactly one done_o pulse; busy_o low in HOLD; load_clear_i pulsed mid-operation does not alter B.
- Reset asserted during SHIFT -> A=B=X=0, busy_o=0 within the same cycle; next run starts cleanly.
- WIDTH=16 FAST=1: B=0x7FFF, S=0x8000 -> {A,B}=0xC0008000, X=1; done_o pulses 17 cycles after the start edge.
